// File: rtl/daq_ctrl_pkg.sv
// Shared types and timing defaults for the multi-ASIC acquisition sequencer.
package daq_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        CHIPRESET     = 4'd1,
        POWOND        = 4'd2,
        RELEASE       = 4'd3,
        ACQUISITION   = 4'd4,
        WAIT          = 4'd5,
        START_READOUT = 4'd6,
        WAIT_READ     = 4'd7,
        END_READOUT   = 4'd8
    } state_t;

    // Hold counts at 40 MHz: 200 ns, 1 us, 400 ns
    localparam int T_PWR_RST_DEF   = 8;
    localparam int T_RST_START_DEF = 40;
    localparam int T_SRO_DEF       = 16;

    function automatic logic is_pwr_d(input state_t s);
        return s inside {POWOND, RELEASE, ACQUISITION, WAIT};
    endfunction

    function automatic logic is_pwr_a(input state_t s);
        return s inside {CHIPRESET, POWOND, RELEASE, ACQUISITION, WAIT, START_READOUT};
    endfunction

endpackage

// File: rtl/daq_ctrl_multi_sync.sv
// Multi-flop synchroniser for an asynchronous pad input, with one-cycle
// rise/fall pulses on the synchronised level.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic Clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sr;
    logic                   q_d;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            sr  <= {SYNC_STAGES{RST_VAL}};
            q_d <= RST_VAL;
        end else begin
            sr  <= {sr[SYNC_STAGES-2:0], d};
            q_d <= sr[SYNC_STAGES-1];
        end
    end

    assign q    = sr[SYNC_STAGES-1];
    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/daq_ctrl_multi.sv
// Acquisition sequencer driving the shared control bus of N_CHIP daisy-chained
// ASICs: reset, acquisition window, readout handshake, power pulsing.
module daq_ctrl_multi
    import daq_ctrl_pkg::*;
#(
    parameter int N_CHIP      = 4,
    parameter int CNT_W       = 16,
    parameter int T_PWR_RST   = T_PWR_RST_DEF,
    parameter int T_RST_START = T_RST_START_DEF,
    parameter int T_SRO       = T_SRO_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int ADC_EN      = 0
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [CNT_W-1:0]  T_acquisition,
    input  logic [CNT_W-1:0]  T_timeout,
    input  logic [N_CHIP-1:0] chip_mask,
    input  logic [N_CHIP-1:0] Chipsatb,
    input  logic              End_Readout,
    output logic              Reset_b,
    output logic              Start_Acq,
    output logic              Start_Readout,
    output logic              Pwr_on_a,
    output logic              Pwr_on_d,
    output logic              Pwr_on_dac,
    output logic              Pwr_on_adc,
    output logic              Once_end,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       acq_count
);

    state_t             state, nxt;
    logic [CNT_W-1:0]   cnt;
    logic               mode_lat, stop_req, set_tmo, tmo_hit;
    logic [N_CHIP-1:0]  chip_sync, chip_rise, chip_fall;
    logic               er_sync, er_rise, rd_end;
    logic               sat, sat_d, full_evt, rd_rdy;

    for (genvar i = 0; i < N_CHIP; i++) begin : g_chip
        sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
            .Clk(Clk), .reset_n(reset_n), .d(Chipsatb[i]),
            .q(chip_sync[i]), .rise(chip_rise[i]), .fall(chip_fall[i])
        );
    end

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_end_sync (
        .Clk(Clk), .reset_n(reset_n), .d(End_Readout),
        .q(er_sync), .rise(er_rise), .fall(rd_end)
    );

    // Only the OR of the masked chips matters, so per-chip edges go unused
    logic unused_sync;
    assign unused_sync = ^{chip_rise, chip_fall, er_sync, er_rise};

    assign sat      = |(~chip_sync & chip_mask);
    assign full_evt = sat & ~sat_d;
    assign rd_rdy   = ~sat & sat_d;
    assign tmo_hit  = (T_timeout != '0) && (cnt == T_timeout);
    assign busy     = (state != IDLE);

    always_comb begin
        nxt     = state;
        set_tmo = 1'b0;
        case (state)
            IDLE:          if (start) nxt = CHIPRESET;
            CHIPRESET:     nxt = POWOND;
            POWOND:        if (cnt == CNT_W'(T_PWR_RST)) nxt = RELEASE;
            RELEASE:       if (cnt == CNT_W'(T_RST_START)) nxt = ACQUISITION;
            ACQUISITION:   if (full_evt || cnt == T_acquisition) nxt = WAIT;
            WAIT: begin
                if (rd_rdy) nxt = START_READOUT;
                else if (tmo_hit) begin
                    nxt     = END_READOUT;
                    set_tmo = 1'b1;
                end
            end
            START_READOUT: if (cnt == CNT_W'(T_SRO)) nxt = WAIT_READ;
            WAIT_READ: begin
                if (rd_end) nxt = END_READOUT;
                else if (tmo_hit) begin
                    nxt     = END_READOUT;
                    set_tmo = 1'b1;
                end
            end
            // timeout_err doubles as the "abort continuous run" flag
            END_READOUT:   nxt = (mode_lat && !stop_req && !timeout_err) ? CHIPRESET : IDLE;
            default:       nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            mode_lat      <= 1'b0;
            stop_req      <= 1'b0;
            timeout_err   <= 1'b0;
            sat_d         <= 1'b0;
            Reset_b       <= 1'b1;
            Start_Acq     <= 1'b0;
            Start_Readout <= 1'b0;
            Pwr_on_a      <= 1'b0;
            Pwr_on_d      <= 1'b0;
            Pwr_on_dac    <= 1'b0;
            Once_end      <= 1'b0;
            acq_count     <= '0;
        end else begin
            state <= nxt;
            sat_d <= sat;
            cnt   <= (nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
            if (state == IDLE && start) begin
                mode_lat    <= mode;
                timeout_err <= 1'b0;
                stop_req    <= 1'b0;
            end else begin
                if (set_tmo) timeout_err <= 1'b1;
                if (stop && state != IDLE) stop_req <= 1'b1;
            end
            // Bus lines are decoded from next state so they move with the state
            Reset_b       <= !(nxt == CHIPRESET || nxt == POWOND);
            Start_Acq     <= (nxt == ACQUISITION);
            Start_Readout <= (nxt == START_READOUT);
            Pwr_on_d      <= is_pwr_d(nxt);
            Pwr_on_a      <= is_pwr_a(nxt);
            Pwr_on_dac    <= is_pwr_a(nxt);
            Once_end      <= (nxt == END_READOUT);
            if (nxt == END_READOUT) acq_count <= acq_count + 16'd1;
        end
    end

    if (ADC_EN != 0) begin : g_adc
        assign Pwr_on_adc = Pwr_on_a;
    end else begin : g_no_adc
        assign Pwr_on_adc = 1'b0;
    end

endmodule
